tone_detect: RTL

TONE_DETECT -- requirements
Module: tone_detect

---
 rtl/tone_detect.sv | 121 ++++++++++++
 1 files changed

// File: rtl/tone_detect.sv
// tone_detect: measures tone half-period in clk cycles, confirms it on two matching samples, snapshots it on tempo ticks.
// Updates land 3 clk after an input transition; no backpressure. Define TONE_DETECT_TOL_EN to accept +/-1 clk jitter.
module tone_detect #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  input  logic             tempo,
  output logic [CNT_W-1:0] div_out,
  output logic             locked,
  output logic [CNT_W-1:0] step_div,
  output logic             step_valid,
  output logic [8:0]       step_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_tone_s1, r_tone_s2, r_tone_d;
  logic             r_tempo_s1, r_tempo_s2, r_tempo_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_prev;
  logic [CNT_W-1:0] r_div;
  logic             r_locked;
  logic [CNT_W-1:0] r_step_div;
  logic             r_step_valid;
  logic [8:0]       r_step_count;

  logic w_tone_edge;
  logic w_tempo_rise;
  logic w_cnt_sat;
  logic w_cnt_pre_sat;
  logic w_sample_ok;
  logic w_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tone_s1  <= 1'b0;
      r_tone_s2  <= 1'b0;
      r_tone_d   <= 1'b0;
      r_tempo_s1 <= 1'b0;
      r_tempo_s2 <= 1'b0;
      r_tempo_d  <= 1'b0;
    end else begin
      r_tone_s1  <= tone_in;
      r_tone_s2  <= r_tone_s1;
      r_tone_d   <= r_tone_s2;
      r_tempo_s1 <= tempo;
      r_tempo_s2 <= r_tempo_s1;
      r_tempo_d  <= r_tempo_s2;
    end
  end

  assign w_tone_edge   = r_tone_s2 ^ r_tone_d;
  assign w_tempo_rise  = r_tempo_s2 & ~r_tempo_d;
  assign w_cnt_sat     = (r_cnt == CNT_MAX);
  assign w_cnt_pre_sat = (r_cnt == CNT_MAX - CNT_ONE);
  // A half-period of 1 clk is a glitch: it only restarts the counter.
  assign w_sample_ok   = (r_cnt > CNT_ONE);

`ifdef TONE_DETECT_TOL_EN
  logic [CNT_W-1:0] w_diff;
  assign w_diff  = (r_cnt >= r_prev) ? (r_cnt - r_prev) : (r_prev - r_cnt);
  assign w_match = (r_prev != '0) && (w_diff <= CNT_ONE);
`else
  assign w_match = (r_cnt == r_prev);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_prev   <= '0;
      r_div    <= '0;
      r_locked <= 1'b0;
    end else if (w_tone_edge) begin
      r_cnt <= CNT_ONE;
      if (w_cnt_sat) begin
        r_prev <= '0;
      end else if (w_sample_ok) begin
        r_prev <= r_cnt;
        if (w_match) begin
          r_div    <= r_cnt;
          r_locked <= 1'b1;
        end else begin
          r_locked <= 1'b0;
        end
      end
    end else if (!w_cnt_sat) begin
      r_cnt <= r_cnt + CNT_ONE;
      // Silence: the counter is about to pin, so report a rest.
      if (w_cnt_pre_sat) begin
        r_div    <= '0;
        r_locked <= 1'b0;
        r_prev   <= '0;
      end
    end
  end

  // r_div is read before this clock's tone update, so a coincident edge sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_div   <= '0;
      r_step_valid <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_step_valid <= w_tempo_rise;
      if (w_tempo_rise) begin
        r_step_div   <= r_div;
        r_step_count <= r_step_count + 9'd1;
      end
    end
  end

  assign div_out    = r_div;
  assign locked     = r_locked;
  assign step_div   = r_step_div;
  assign step_valid = r_step_valid;
  assign step_count = r_step_count;

endmodule
